// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the memory-domain power sequencer.
// State encodings are visible on state_o, so they are fixed here.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_SAVE    = 3'd1,
    ST_ISO     = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWR_ON  = 3'd4,
    ST_RESTORE = 3'd5,
    ST_UNISO   = 3'd6
  } pwr_state_e;

  localparam logic [1:0] REG_THRESH = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FORCE_BIT = 1;
  localparam int CTRL_STEP_LSB  = 2;
  localparam int CTRL_STEP_W    = 3;

  typedef struct packed {
    logic pwr_up;
    logic iso_up;
    logic save;
    logic restore;
    logic asleep;
  } pwr_out_t;

  // Isolation stays up from ISO through RESTORE so outputs are clamped
  // whenever the domain is unpowered or not yet restored.
  function automatic pwr_out_t decode_outputs(pwr_state_e s);
    pwr_out_t o;
    o.pwr_up  = (s != ST_OFF);
    o.iso_up  = (s == ST_ISO) || (s == ST_OFF) || (s == ST_PWR_ON) ||
                (s == ST_RESTORE);
    o.save    = (s == ST_SAVE);
    o.restore = (s == ST_RESTORE);
    o.asleep  = (s == ST_OFF);
    return o;
  endfunction

endpackage

// File: rtl/pwr_seq_if.sv
// Register-write bus from csr and power-control bundle towards mem_ctrl.
interface pwr_seq_if;
  logic       reg_wr;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       pwr_up;
  logic       iso_up;
  logic       save;
  logic       restore;

  modport master (
    output reg_wr, reg_sel, reg_data,
    input  pwr_up, iso_up, save, restore
  );

  modport slave (
    input  reg_wr, reg_sel, reg_data,
    output pwr_up, iso_up, save, restore
  );
endinterface

// File: rtl/pwr_idle_cnt.sv
// Saturating idle-cycle counter; hit when the count reaches max(thresh,1)-1.
module pwr_idle_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] thresh,
  output logic             hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  // A zero threshold behaves like one: sleep after a single idle cycle.
  assign limit = (thresh == '0) ? '0 : thresh - CNT_W'(1);
  assign hit   = (cnt >= limit);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwr_seq.sv
// Power-domain sequencer: idle-driven save/isolate/power-off and the
// matching power-on/restore/de-isolate wake path for the memory domain.
module pwr_seq
  import pwr_seq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 6,
  parameter int DEF_THRESH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] idle,
  input  logic              wake_req,
  pwr_seq_if.slave          bus,
  output logic              asleep,
  output logic [2:0]        state_o
);

  logic [CNT_W-1:0]       thresh;
  logic                   enable;
  logic                   force_on;
  logic [CTRL_STEP_W-1:0] step;
  logic [NUM_CH-1:0]      mask;

  logic all_idle;
  logic go_sleep;
  logic wake;
  logic cnt_inc;
  logic cnt_hit;

  pwr_state_e             state;
  pwr_state_e             state_n;
  logic [CTRL_STEP_W-1:0] dly_cnt;
  logic                   dly_load;
  pwr_out_t               outs_q;

  logic unused_reg_bits;
  assign unused_reg_bits = ^bus.reg_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thresh   <= CNT_W'(DEF_THRESH);
      enable   <= 1'b0;
      force_on <= 1'b0;
      step     <= '0;
      mask     <= '1;
    end else if (bus.reg_wr) begin
      case (bus.reg_sel)
        REG_THRESH: thresh <= bus.reg_data[CNT_W-1:0];
        REG_CTRL: begin
          enable   <= bus.reg_data[CTRL_EN_BIT];
          force_on <= bus.reg_data[CTRL_FORCE_BIT];
          step     <= bus.reg_data[CTRL_STEP_LSB +: CTRL_STEP_W];
        end
        REG_MASK: mask <= bus.reg_data[NUM_CH-1:0];
        default: ;
      endcase
    end
  end

  // Masked channels count as idle; a CSR access always holds the domain awake.
  assign all_idle = (&(idle | ~mask)) & ~wake_req;
  assign go_sleep = all_idle & enable & ~force_on;
  assign wake     = ~go_sleep;
  assign cnt_inc  = all_idle && (state == ST_ON);

  pwr_idle_cnt #(
    .CNT_W (CNT_W)
  ) u_idle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (!cnt_inc),
    .inc    (cnt_inc),
    .thresh (thresh),
    .hit    (cnt_hit)
  );

  // NOTE: state_n gets a default before the case so no path infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      ST_ON:      if (go_sleep && cnt_hit) state_n = ST_SAVE;
      ST_SAVE:    state_n = go_sleep ? ST_ISO : ST_ON;
      ST_ISO: begin
        if (wake)                 state_n = ST_UNISO;
        else if (dly_cnt == '0)   state_n = ST_OFF;
      end
      ST_OFF:     if (wake) state_n = ST_PWR_ON;
      ST_PWR_ON:  if (dly_cnt == '0) state_n = ST_RESTORE;
      ST_RESTORE: state_n = ST_UNISO;
      ST_UNISO:   state_n = ST_ON;
      default:    state_n = ST_ON;
    endcase
  end

  // The step delay is loaded with step (D-1) on entry so ISO and PWR_ON last D cycles.
  assign dly_load = ((state_n == ST_ISO)    && (state != ST_ISO)) ||
                    ((state_n == ST_PWR_ON) && (state != ST_PWR_ON));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_ON;
      dly_cnt <= '0;
      outs_q  <= decode_outputs(ST_ON);
    end else begin
      state  <= state_n;
      outs_q <= decode_outputs(state_n);
      if (dly_load) begin
        dly_cnt <= step;
      end else if (dly_cnt != '0) begin
        dly_cnt <= dly_cnt - CTRL_STEP_W'(1);
      end
    end
  end

  assign bus.pwr_up  = outs_q.pwr_up;
  assign bus.iso_up  = outs_q.iso_up;
  assign bus.save    = outs_q.save;
  assign bus.restore = outs_q.restore;
  assign asleep      = outs_q.asleep;
  assign state_o     = state;

endmodule

// File: tb/tb_pwr_seq.sv
// Scoreboard bench for pwr_seq: expected output vectors are queued per cycle
// when stimulus is applied and compared on the falling edge of that cycle.
module tb_pwr_seq;
  import pwr_seq_pkg::*;

  // {state_o, pwr_up, iso_up, save, restore, asleep}
  localparam logic [7:0] V_ON      = 8'b000_10000;
  localparam logic [7:0] V_SAVE    = 8'b001_10100;
  localparam logic [7:0] V_ISO     = 8'b010_11000;
  localparam logic [7:0] V_OFF     = 8'b011_01001;
  localparam logic [7:0] V_PWR_ON  = 8'b100_11000;
  localparam logic [7:0] V_RESTORE = 8'b101_11010;
  localparam logic [7:0] V_UNISO   = 8'b110_10000;

  typedef struct {
    int         at;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] idle;
  logic       wake_req;
  logic       asleep;
  logic [2:0] state_o;
  logic [7:0] obs;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pwr_seq_if bus ();

  pwr_seq #(
    .NUM_CH     (4),
    .CNT_W      (6),
    .DEF_THRESH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .idle     (idle),
    .wake_req (wake_req),
    .bus      (bus),
    .asleep   (asleep),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {state_o, bus.pwr_up, bus.iso_up, bus.save, bus.restore, asleep};

  function automatic void push_exp(input int at, input logic [7:0] v, input string nm);
    sb.push_back('{at, v, nm});
  endfunction

  task automatic write_reg(input logic [1:0] sel, input logic [7:0] data);
    bus.reg_wr   = 1'b1;
    bus.reg_sel  = sel;
    bus.reg_data = data;
    @(negedge clk);
    bus.reg_wr   = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (2) @(negedge clk);
    push_exp(cyc + 1, V_ON, "in_reset");
    repeat (1) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
    reset = 1'b1;
    push_exp(cyc + 1, V_ON, "reset_release_1");
    push_exp(cyc + 2, V_ON, "reset_release_2");
    repeat (2) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_sleep();
    exp_t e;
    int   base;
    write_reg(REG_THRESH, 8'd4);
    write_reg(REG_CTRL, 8'h01);
    idle = '1;
    base = cyc;
    push_exp(base + 3, V_ON,   "sleep_still_on");
    push_exp(base + 4, V_SAVE, "sleep_save");
    push_exp(base + 5, V_ISO,  "sleep_iso");
    push_exp(base + 6, V_OFF,  "sleep_off");
    push_exp(base + 8, V_OFF,  "sleep_stays_off");
    repeat (8) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_wake();
    exp_t e;
    int   w;
    write_reg(REG_CTRL, 8'h0D);
    idle = 4'b1011;
    w = cyc;
    push_exp(w + 1, V_PWR_ON,  "wake_pwr_on_first");
    push_exp(w + 4, V_PWR_ON,  "wake_pwr_on_last");
    push_exp(w + 5, V_RESTORE, "wake_restore");
    push_exp(w + 6, V_UNISO,   "wake_uniso");
    push_exp(w + 7, V_ON,      "wake_on");
    push_exp(w + 9, V_ON,      "wake_stays_on");
    repeat (9) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_iso_abort();
    exp_t e;
    int   base;
    int   pwr_drops = 0;
    int   restores = 0;
    write_reg(REG_CTRL, 8'h1D);
    idle = '1;
    base = cyc;
    push_exp(base + 4,  V_SAVE,  "abort_save");
    push_exp(base + 5,  V_ISO,   "abort_iso_enter");
    push_exp(base + 7,  V_ISO,   "abort_iso_wait");
    push_exp(base + 8,  V_UNISO, "abort_uniso");
    push_exp(base + 9,  V_ON,    "abort_on");
    push_exp(base + 11, V_ON,    "abort_stays_on");
    repeat (11) begin
      @(negedge clk);
      if (!bus.pwr_up) pwr_drops++;
      if (bus.restore) restores++;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
      if (cyc == base + 7) wake_req = 1'b1;
      if (cyc == base + 8) begin
        wake_req = 1'b0;
        idle     = '0;
      end
    end
    checks++;
    if (pwr_drops != 0) begin
      errors++;
      $display("FAIL abort_pwr_kept: pwr_up low in %0d cycles, expected 0", pwr_drops);
    end
    checks++;
    if (restores != 0) begin
      errors++;
      $display("FAIL abort_no_restore: %0d restore cycles, expected 0", restores);
    end
  endtask

  task automatic test_mask();
    exp_t e;
    int   base;
    write_reg(REG_THRESH, 8'd2);
    write_reg(REG_CTRL, 8'h01);
    idle = 4'b1011;
    write_reg(REG_MASK, 8'h0B);
    base = cyc;
    push_exp(base + 1, V_ON,   "mask_on");
    push_exp(base + 2, V_SAVE, "mask_save");
    push_exp(base + 3, V_ISO,  "mask_iso");
    push_exp(base + 4, V_OFF,  "mask_off");
    push_exp(base + 5, V_OFF,  "mask_stays_off");
    repeat (5) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
    write_reg(REG_MASK, 8'h0F);
    base = cyc;
    push_exp(base + 1, V_PWR_ON,  "unmask_pwr_on");
    push_exp(base + 2, V_RESTORE, "unmask_restore");
    push_exp(base + 3, V_UNISO,   "unmask_uniso");
    push_exp(base + 4, V_ON,      "unmask_on");
    repeat (4) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_break_and_zero();
    exp_t e;
    int   base;
    write_reg(REG_THRESH, 8'd4);
    idle = '1;
    base = cyc;
    push_exp(base + 4, V_ON,   "break_no_save_4");
    push_exp(base + 5, V_ON,   "break_no_save_5");
    push_exp(base + 6, V_ON,   "break_no_save_6");
    push_exp(base + 7, V_SAVE, "break_save_after_rerun");
    push_exp(base + 8, V_ON,   "save_abort_on");
    push_exp(base + 9, V_ON,   "save_abort_stays_on");
    repeat (9) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
      if (cyc == base + 2) idle = 4'b1011;
      if (cyc == base + 3) idle = '1;
      if (cyc == base + 7) idle = '0;
    end
    write_reg(REG_THRESH, 8'd0);
    idle = '1;
    base = cyc;
    push_exp(base + 1, V_SAVE, "zero_thresh_save");
    push_exp(base + 2, V_ISO,  "zero_thresh_iso");
    push_exp(base + 3, V_OFF,  "zero_thresh_off");
    repeat (3) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   base;
    int   saves = 0;
    write_reg(REG_CTRL, 8'h0D);
    idle = '0;
    base = cyc;
    push_exp(base + 1, V_PWR_ON, "mid_pwr_on_1");
    push_exp(base + 2, V_PWR_ON, "mid_pwr_on_2");
    repeat (2) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
    #2 reset = 1'b0;
    #1;
    push_exp(cyc, V_ON, "async_reset_now");
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    idle  = '1;
    base  = cyc;
    push_exp(base + 40, V_ON, "post_reset_disabled");
    repeat (40) begin
      @(negedge clk);
      if (bus.save) saves++;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
    checks++;
    if (saves != 0) begin
      errors++;
      $display("FAIL post_reset_no_save: %0d save pulses, expected 0", saves);
    end
    idle = '0;
    write_reg(REG_CTRL, 8'h01);
    idle = '1;
    base = cyc;
    push_exp(base + 15, V_ON,   "default_thresh_on");
    push_exp(base + 16, V_SAVE, "default_thresh_save");
    repeat (16) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b expected %b", e.name, cyc, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    idle         = '0;
    wake_req     = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.reg_sel  = '0;
    bus.reg_data = '0;
    test_reset();
    test_sleep();
    test_wake();
    test_iso_abort();
    test_mask();
    test_break_and_zero();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwr_seq.md
# pwr_seq

Parametrised power-domain sequencer for the shared memory domain; next generation of the single-domain power controller. Monitors NUM_CH channel idle flags plus a CSR wake request. After a programmable run of idle cycles it drives save → isolate → power-off, and on wake it drives power-on → restore → de-isolate. Sits between the rx/tx channel blocks and csr on one side and mem_ctrl's iso_up/pwr_up/save/restore inputs on the other.

## Interface
- NUM_CH, 4, number of idle inputs monitored; 1..8
- CNT_W, 6, idle-counter and threshold width; 1..8
- DEF_THRESH, 16, threshold reset value; must fit in CNT_W bits
- clk  in  1  clock, all state on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- idle  in  NUM_CH  per-channel idle flag, 1 = idle
- wake_req  in  1  CSR access to the memory domain (level); forces wake and blocks sleep
- reg_wr  in  1  one-cycle register write strobe
- reg_sel  in  2  0 = threshold, 1 = control, 2 = channel mask, 3 = reserved (write ignored)
- reg_data  in  8  write data
- pwr_up  out  1  domain power on
- iso_up  out  1  domain outputs isolated
- save  out  1  one-cycle retention save pulse
- restore  out  1  one-cycle retention restore pulse
- asleep  out  1  state == OFF
- state_o  out  3  current state encoding

## Operation
- Registers: thresh[CNT_W-1:0] (reset DEF_THRESH); ctrl: bit0 enable (reset 0), bit1 force_on (reset 0), bits[4:2] step (reset 0, delay D = step+1 cycles, 1..8); mask[NUM_CH-1:0] (reset all 1 = monitored). Unused reg_data bits ignored.
- all_idle = AND over i of (idle[i] | ~mask[i]), and ~wake_req. Mask 0 → all_idle = ~wake_req.
- go_sleep = all_idle & enable & ~force_on. wake = ~go_sleep.
- Idle counter: cleared when ~all_idle or state ≠ ON; otherwise increments, saturating at 2^CNT_W-1.
- States (encoding): ON 0, SAVE 1, ISO 2, OFF 3, PWR_ON 4, RESTORE 5, UNISO 6.
- ON → SAVE when go_sleep and cnt ≥ max(thresh,1) - 1 in the same cycle.
- SAVE (save=1): next ISO if go_sleep, else ON (save already issued; no restore needed).
- ISO (iso_up=1): wait D cycles then OFF; wake during wait → UNISO.
- OFF (iso_up=1, pwr_up=0): wake → PWR_ON.
- PWR_ON (pwr_up=1, iso_up=1): wait D cycles → RESTORE. Wake-sequence states ignore go_sleep.
- RESTORE (restore=1, iso_up=1): one cycle → UNISO.
- UNISO (iso_up=0): one cycle → ON; counter restarts from 0.
- Register writes take effect the cycle after reg_wr; a write in any state is legal. Clearing enable or setting force_on while OFF/ISO is a wake.

## Timing
- All outputs registered, decoded from next-state. Reset values: pwr_up=1, iso_up=0, save=0, restore=0, asleep=0, state_o=0 (ON).
- Idle cycles all_idle high starting at edge 0 with thresh = T ≥ 1: save high in cycle T; iso_up rises T+1; pwr_up falls T+1+D.
- Wake seen in OFF at cycle W: pwr_up rises W+1; restore high W+1+D; iso_up falls W+2+D; state_o = ON from W+3+D.
- save and restore never high together; iso_up is high whenever pwr_up is low; pwr_up never falls without a preceding save pulse since the last restore/ON entry.
- reset asserted mid-sequence returns to reset values immediately (asynchronous); registers return to defaults.

## Structure
- Package pwr_seq_pkg: state enum and encodings, reg_sel codes, ctrl field bit positions.
- Sub-module pwr_idle_cnt: saturating idle counter with threshold compare (CNT_W parameter, clear/inc inputs, hit output).
- Step-delay down-counter (3 bits) lives in pwr_seq.

## Test plan
- Reset, write ctrl=0x01, thresh=4, all idle=1 → save pulse in cycle 4, iso_up at 5, pwr_up=0 at 6, asleep=1.
- From OFF with step=3 (D=4), drop idle[2] at cycle W → pwr_up=1 at W+1, restore at W+5, iso_up=0 at W+6, state ON at W+7.
- Wake_req pulse during ISO wait (step=7) → UNISO then ON, no restore pulse, pwr_up never deasserted.
- Mask=0x0B with idle[2] held 0, others idle, thresh=2 → sleep proceeds; unmask bit 2 while OFF → wake sequence starts next cycle.
- Idle run broken at cnt=thresh-2 → counter clears, no save; thresh=0 with enable → save after 1 idle cycle.
- Assert reset in PWR_ON → all outputs at reset values same cycle, enable=0 afterwards, no further sleep.
